keypad_scanner: RTL and testbench

// - Input-side counterpart of the 7-segment display multiplexer. The display block drives the board outputs; this block reads the 4x4 matrix keypad.
// - Drives one-hot row lines (fil) and samples the column lines (col).
// - Debounces a single pressed key and emits a 4-bit key code with a one-cycle valid pulse.
// - Feeds dividend/divisor entry into principal, alongside SW.

---
 rtl/keypad_scanner_pkg.sv | 35 +++
 rtl/scan_tick_gen.sv | 27 ++
 rtl/keypad_scanner.sv | 129 ++++++++++++
 tb/tb_keypad_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// - FSM state encodings
// - one-hot row drive constants and the key code width
// - one-hot to index helper and row rotate helper
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  localparam int KEY_W = 4;

  // Index of the highest set bit; callers only pass one-hot values.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Rotate the row drive left; 1000 wraps to 0001.
  function automatic logic [3:0] row_next(input logic [3:0] row);
    return {row[2:0], row[3]};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan prescaler.
// Ports:
//   clk     in  system clock
//   btnres  in  asynchronous active-high reset
//   tick    out one-cycle strobe every SCAN_DIV clocks (while count is SCAN_DIV-1)
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic btnres,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge btnres) begin
    if (btnres)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce.
// Drives one row at a time, samples the synchronized columns on each scan
// tick, debounces a single key and reports it with a one-cycle valid pulse.
// Ports:
//   clk        in  system clock
//   btnres     in  asynchronous active-high reset
//   col[3:0]   in  column lines, active-high, asynchronous to clk
//   fil[3:0]   out one-hot row drive
//   key_code   out last accepted key, {row_idx, col_idx}
//   key_valid  out one-cycle pulse when key_code updates
//   key_held   out high until the accepted key is released
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 20
) (
  input  logic             clk,
  input  logic             btnres,
  input  logic [3:0]       col,
  output logic [3:0]       fil,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DW = $clog2(DEBOUNCE_N);
  // Counters stop at N-1: the Nth matching tick is the accepting one.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_N - 1);

  logic tick;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .btnres (btnres),
    .tick   (tick)
  );

  state_t          state, state_n;
  logic [3:0]      col_m, col_s;
  logic [3:0]      cand_col, cand_n;
  logic [3:0]      fil_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic [DW-1:0]   rel_cnt, rel_n;
  logic [KEY_W-1:0] code_n;
  logic            valid_n, held_n;

  always_ff @(posedge clk or posedge btnres) begin
    if (btnres) begin
      col_m     <= '0;
      col_s     <= '0;
      state     <= SCAN;
      fil       <= ROW0;
      cand_col  <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      state     <= state_n;
      fil       <= fil_n;
      cand_col  <= cand_n;
      deb_cnt   <= deb_n;
      rel_cnt   <= rel_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    fil_n   = fil;
    cand_n  = cand_col;
    deb_n   = deb_cnt;
    rel_n   = rel_cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (tick) begin
      unique case (state)
        SCAN: begin
          // Zero or multi-hot columns (two keys, ghosting) just move on.
          if ($onehot(col_s)) begin
            cand_n  = col_s;
            deb_n   = DW'(1);
            state_n = DEBOUNCE;
          end else begin
            fil_n = row_next(fil);
          end
        end
        DEBOUNCE: begin
          if (col_s == cand_col) begin
            if (deb_cnt == DEB_LAST) begin
              code_n  = {onehot_to_idx(fil), onehot_to_idx(cand_col)};
              valid_n = 1'b1;
              held_n  = 1'b1;
              rel_n   = '0;
              state_n = PRESSED;
            end else begin
              deb_n = deb_cnt + 1'b1;
            end
          end else begin
            // Bounce: retry the same row without rotating.
            state_n = SCAN;
          end
        end
        PRESSED: begin
          if (col_s == '0) begin
            if (rel_cnt == DEB_LAST) begin
              held_n  = 1'b0;
              fil_n   = row_next(fil);
              state_n = SCAN;
            end else begin
              rel_n = rel_cnt + 1'b1;
            end
          end else begin
            rel_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=3.
// A small matrix model turns the set of pressed keys into column levels
// for whichever row is currently driven.
module tb_keypad_scanner;

  logic       clk;
  logic       btnres;
  logic [3:0] col;
  logic [3:0] fil;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;   // bit r*4+c = key at row r, column c pressed

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .clk       (clk),
    .btnres    (btnres),
    .col       (col),
    .fil       (fil),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always_comb begin
    col = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (fil[r]) col = col | keys[r*4 +: 4];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count valid pulses and make sure each lasts exactly one cycle.
  always @(negedge clk) begin
    if (!btnres) begin
      if (key_valid) begin
        pulses++;
        chk("valid_width", {31'd0, prev_valid}, 32'd0);
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic reset_pulse(input string tag);
    btnres = 1'b1;
    keys   = 16'h0000;
    #1;
    chk({tag, "_fil"},   {28'd0, fil},      32'h1);
    chk({tag, "_code"},  {28'd0, key_code}, 32'h0);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'h0);
    chk({tag, "_held"},  {31'd0, key_held}, 32'h0);
    @(negedge clk);
    #2;
    btnres = 1'b0;
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        toggle;   // keys on/off alternating every scan tick
    int          ncyc;
    int          pulses;
    logic [3:0]  code;
    logic        held;
    logic [3:0]  fil;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int p0;
    vecs[0]  = '{16'h0000, 1'b0, 368, 0, 4'h0, 1'b0, 4'b0001}; // idle to 100 ticks
    vecs[1]  = '{16'h0200, 1'b0, 160, 1, 4'h9, 1'b1, 4'b0100}; // row2/col1 held
    vecs[2]  = '{16'h0000, 1'b0,  11, 0, 4'h9, 1'b1, 4'b0100}; // release not yet accepted
    vecs[3]  = '{16'h0000, 1'b0,   1, 0, 4'h9, 1'b0, 4'b1000}; // third quiet tick
    vecs[4]  = '{16'h0000, 1'b0,  12, 0, 4'h9, 1'b0, 4'b0100};
    vecs[5]  = '{16'h0200, 1'b1,  40, 0, 4'h9, 1'b0, 4'b0100}; // bounce, row frozen
    vecs[6]  = '{16'h0200, 1'b0,  12, 1, 4'h9, 1'b1, 4'b0100}; // stable after bounce
    vecs[7]  = '{16'h8200, 1'b0,  40, 0, 4'h9, 1'b1, 4'b0100}; // second key ignored
    vecs[8]  = '{16'h8000, 1'b0,  12, 0, 4'h9, 1'b0, 4'b1000}; // first key released
    vecs[9]  = '{16'h8000, 1'b0,  13, 1, 4'hF, 1'b1, 4'b1000}; // row3/col3 accepted
    vecs[10] = '{16'h0000, 1'b0,  12, 0, 4'hF, 1'b0, 4'b0001};
    vecs[11] = '{16'h0003, 1'b0,   4, 0, 4'hF, 1'b0, 4'b0010}; // multi-hot row0
    vecs[12] = '{16'h0003, 1'b0,  36, 0, 4'hF, 1'b0, 4'b0100};

    btnres = 1'b1;
    keys   = 16'h0000;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_fil",   {28'd0, fil},       32'h1);
    chk("rst_code",  {28'd0, key_code},  32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_held",  {31'd0, key_held},  32'h0);
    btnres = 1'b0;

    // Idle rotation: row changes every 4 clocks starting from 0001.
    for (int k = 1; k <= 32; k++) begin
      logic [3:0] exp_fil;
      @(negedge clk);
      #2;
      exp_fil = 4'b0001 << ((k / 4) % 4);
      chk("idle_fil", {28'd0, fil}, {28'd0, exp_fil});
    end

    for (int i = 0; i < 13; i++) begin
      p0 = pulses;
      if (vecs[i].toggle) begin
        for (int j = 0; j < vecs[i].ncyc / 4; j++) begin
          keys = (j % 2 == 0) ? vecs[i].keys : 16'h0000;
          run(4);
        end
      end else begin
        keys = vecs[i].keys;
        run(vecs[i].ncyc);
      end
      chk($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].pulses);
      chk($sformatf("v%0d_code", i), {28'd0, key_code}, {28'd0, vecs[i].code});
      chk($sformatf("v%0d_held", i), {31'd0, key_held}, {31'd0, vecs[i].held});
      chk($sformatf("v%0d_fil", i), {28'd0, fil}, {28'd0, vecs[i].fil});
    end

    // Reset in the middle of a debounce: row stays frozen until reset.
    p0 = pulses;
    keys = 16'h0200;
    run(3);
    chk("deb_fil", {28'd0, fil}, 32'h4);
    reset_pulse("rst_deb");
    run(20);
    chk("after_deb_pulses", pulses - p0, 0);
    chk("after_deb_code", {28'd0, key_code}, 32'h0);
    chk("after_deb_fil", {28'd0, fil}, 32'h2);

    // Fresh press after reset, then reset while it is held.
    p0 = pulses;
    keys = 16'h0200;
    run(20);
    chk("pr_pulses", pulses - p0, 1);
    chk("pr_code", {28'd0, key_code}, 32'h9);
    chk("pr_held", {31'd0, key_held}, 32'h1);
    p0 = pulses;
    reset_pulse("rst_prs");
    run(20);
    chk("after_prs_pulses", pulses - p0, 0);
    chk("after_prs_code", {28'd0, key_code}, 32'h0);
    chk("after_prs_held", {31'd0, key_held}, 32'h0);
    chk("after_prs_fil", {28'd0, fil}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
